// File: rtl/mem_access_unit.sv
// MEM-stage front end: latches one load/store, runs a req/ack memory handshake with timeout, stalls the CPU meanwhile.
// Latency 1+N stall cycles (N = REQ cycles to ack); no queueing, one access outstanding at a time.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic access, aligned;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (addr_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    mis_d   = 1'b0;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            addr_d  = addr_i;
            wdata_d = data_i;
            we_d    = MemWrite_i;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            mis_d  = 1'b1;
            data_d = '0;
          end
        end
      end
      REQ: begin
        // ack wins over a timeout landing in the same cycle
        if (mem_ack_i) begin
          req_d   = 1'b0;
          if (!we_q) data_d = mem_rdata_i;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          data_d  = '0;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall rises in the detect cycle so the CPU freezes before the request is even issued
  assign stall_o = rst_i & ((state_q == REQ) | ((state_q == IDLE) & access & aligned));

  assign data_o      = data_q;
  assign misalign_o  = mis_q;
  assign timeout_o   = to_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses checked every cycle against a transaction-level model.
module tb_mem_access_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0, mem_rdata_i = '0;
  logic [31:0] data_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, misalign_o, timeout_o, mem_req_o, mem_we_o;

  int errors = 0, checks = 0;
  int stall_cnt = 0, mis_cnt = 0, req_rise = 0;
  logic req_prev = 1'b0;
  int n;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: an access is either outstanding (busy) or retiring (one cycle).
  bit          m_busy = 0, m_retire = 0, m_req = 0, m_we = 0, m_mis = 0, m_to = 0;
  int          m_waited = 0;
  logic [31:0] m_data = '0, m_addr = '0, m_wdata = '0;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_busy = 0; m_retire = 0; m_req = 0; m_we = 0; m_mis = 0; m_to = 0;
      m_waited = 0; m_data = '0; m_addr = '0; m_wdata = '0;
    end else begin
      m_mis = 0;
      if (m_retire) begin
        m_retire = 0;
      end else if (m_busy) begin
        if (mem_ack_i) begin
          m_busy = 0; m_retire = 1; m_req = 0;
          if (!m_we) m_data = mem_rdata_i;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_busy = 0; m_retire = 1; m_req = 0; m_data = '0; m_to = 1;
          end
        end
      end else if (MemRead_i || MemWrite_i) begin
        if (addr_i % 4 == 0) begin
          m_busy = 1; m_waited = 0; m_req = 1;
          m_addr = addr_i; m_wdata = data_i; m_we = MemWrite_i;
        end else begin
          m_mis = 1; m_data = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = rst_i && (m_busy || (!m_retire && (MemRead_i || MemWrite_i) && addr_i % 4 == 0));
    chk("stall_o", 32'(stall_o), 32'(exp_stall));
    chk("data_o", data_o, m_data);
    chk("misalign_o", 32'(misalign_o), 32'(m_mis));
    chk("timeout_o", 32'(timeout_o), 32'(m_to));
    chk("mem_req_o", 32'(mem_req_o), 32'(m_req));
    chk("mem_we_o", 32'(mem_we_o), 32'(m_we));
    chk("mem_addr_o", mem_addr_o, m_addr);
    chk("mem_wdata_o", mem_wdata_o, m_wdata);
    if (stall_o) stall_cnt++;
    if (misalign_o) mis_cnt++;
    if (mem_req_o && !req_prev) req_rise++;
    req_prev = mem_req_o;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One access; ack_at = REQ cycle carrying the ack (0 = never). Returns stall cycles seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rdat, output int stalls);
    int s0;
    s0 = stall_cnt;
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; data_i = d;
    step();
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    if (a[1:0] == 2'b00) begin
      for (int k = 1; k <= TO; k++) begin
        if (k == ack_at) begin
          mem_ack_i = 1'b1; mem_rdata_i = rdat;
          step();
          mem_ack_i = 1'b0;
          break;
        end
        step();
      end
      step();
    end
    stalls = stall_cnt - s0;
  endtask

  initial begin
    int r0, m0;
    #7;
    chk("reset data_o", data_o, 32'h0);
    chk("reset mem_req_o", 32'(mem_req_o), 32'h0);
    chk("reset stall_o", 32'(stall_o), 32'h0);
    chk("reset timeout_o", 32'(timeout_o), 32'h0);
    chk("reset mem_addr_o", mem_addr_o, 32'h0);
    step(); step();
    rst_i = 1'b1;
    step();

    access(1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hCAFE_F00D, n);
    chk("load stall cycles", 32'(n), 32'd4);
    chk("load data_o", data_o, 32'hCAFE_F00D);
    chk("load addr", mem_addr_o, 32'h10);

    access(1'b0, 1'b1, 32'h24, 32'h1234_5678, 1, 32'hFFFF_FFFF, n);
    chk("store stall cycles", 32'(n), 32'd2);
    chk("store data_o kept", data_o, 32'hCAFE_F00D);
    chk("store wdata", mem_wdata_o, 32'h1234_5678);
    chk("store we", 32'(mem_we_o), 32'h1);

    MemRead_i = 1'b1; addr_i = 32'h40;
    step();
    MemRead_i = 1'b0;
    step();
    rst_i = 1'b0;
    #1;
    chk("async reset mem_req_o", 32'(mem_req_o), 32'h0);
    chk("async reset stall_o", 32'(stall_o), 32'h0);
    chk("async reset data_o", data_o, 32'h0);
    step();
    rst_i = 1'b1;
    step();
    access(1'b1, 1'b0, 32'h40, 32'h0, 2, 32'h0BAD_F00D, n);
    chk("post-reset load data", data_o, 32'h0BAD_F00D);
    chk("post-reset stall cycles", 32'(n), 32'd3);

    r0 = req_rise; m0 = mis_cnt;
    access(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0, n);
    step();
    chk("misalign stall cycles", 32'(n), 32'd0);
    chk("misalign pulses", 32'(mis_cnt - m0), 32'd1);
    chk("misalign no request", 32'(req_rise - r0), 32'd0);
    chk("misalign data_o", data_o, 32'h0);

    access(1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h0, n);
    chk("timeout stall cycles", 32'(n), 32'd17);
    chk("timeout flag", 32'(timeout_o), 32'h1);
    chk("timeout data_o", data_o, 32'h0);
    access(1'b1, 1'b0, 32'h84, 32'h0, 2, 32'h5555_AAAA, n);
    chk("after timeout data", data_o, 32'h5555_AAAA);
    chk("timeout sticky", 32'(timeout_o), 32'h1);

    MemRead_i = 1'b1; addr_i = 32'h10;
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("b2b DONE stall", 32'(stall_o), 32'h0);
    chk("b2b DONE req", 32'(mem_req_o), 32'h0);
    step();
    #1;
    chk("b2b IDLE stall", 32'(stall_o), 32'h1);
    chk("b2b IDLE req", 32'(mem_req_o), 32'h0);
    step();
    chk("b2b second req", 32'(mem_req_o), 32'h1);
    MemRead_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h3333_4444;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("b2b second data", data_o, 32'h3333_4444);

    MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h30; data_i = 32'hDEAD_BEEF;
    step();
    chk("both high we", 32'(mem_we_o), 32'h1);
    chk("both high wdata", mem_wdata_o, 32'hDEAD_BEEF);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h9999_9999;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("both high data_o kept", data_o, 32'h3333_4444);

    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("stray ack data_o", data_o, 32'h3333_4444);
    chk("stray ack req", 32'(mem_req_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
